// File: rtl/rpn_pkg.sv
// Shared token, operator and FSM state encodings
// for the RPN stack engine.
package rpn_pkg;

    typedef enum logic [1:0] {
        K_OPND = 2'b00,
        K_OPER = 2'b01,
        K_END  = 2'b10,
        K_RSVD = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PUSH,
        S_POP_B,
        S_POP_A,
        S_EXEC,
        S_PUSH_R,
        S_FIN,
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/rpn_stack_engine_if.sv
// Token stream handshake between a token source
// (master) and the RPN engine (slave).
interface rpn_stack_engine_if #(
    parameter int DATA_W = 8
);
    logic              Tok_Valid;
    logic              Tok_Ready;
    logic [1:0]        Tok_Kind;
    logic [DATA_W-1:0] Tok_Data;

    modport master (
        output Tok_Valid,
        output Tok_Kind,
        output Tok_Data,
        input  Tok_Ready
    );

    modport slave (
        input  Tok_Valid,
        input  Tok_Kind,
        input  Tok_Data,
        output Tok_Ready
    );
endinterface

// File: rtl/rpn_alu.sv
// Combinational ALU; a is the earlier-pushed operand,
// all results wrap modulo 2**DATA_W.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  op_e               op,
    output logic [DATA_W-1:0] r
);

    // Operator decode
    always_comb begin
        r = '0;
        unique case (op)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_AND: r = a & b;
            OP_XOR: r = a ^ b;
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/rpn_stack_engine.sv
// RPN evaluator driving one pushdown stack; the local
// depth counter decides under/overflow, stack flags cross-check.
module rpn_stack_engine
    import rpn_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Clear,
    rpn_stack_engine_if.slave tok,
    output logic [DATA_W-1:0] Result,
    output logic              Res_Valid,
    output logic              Error,
    output logic [DATA_W-1:0] St_I,
    input  logic [DATA_W-1:0] St_O,
    output logic              St_PushPop,
    output logic              St_Enable,
    output logic              St_Reset,
    input  logic              St_Empty,
    input  logic              St_Full
);

    localparam logic [ADDR_W-1:0] MAX_DEPTH = '1;
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

    state_e            state, state_n;
    logic [ADDR_W-1:0] depth, depth_n;
    logic              was_err;
    logic              accept;
    logic              tok_ready;
    logic [DATA_W-1:0] lat_q;
    logic [DATA_W-1:0] a_q, b_q, r_q;
    logic [DATA_W-1:0] alu_r;

    assign tok.Tok_Ready = tok_ready;

    rpn_alu #(.DATA_W(DATA_W)) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_e'(lat_q[1:0])),
        .r  (alu_r)
    );

    // State, depth and error-entry tracking
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= S_IDLE;
            depth   <= '0;
            was_err <= 1'b0;
        end else begin
            state   <= state_n;
            depth   <= depth_n;
            was_err <= (state == S_ERR);
        end
    end

    // Next state, depth update and stack/handshake outputs
    always_comb begin
        state_n    = state;
        depth_n    = depth;
        tok_ready  = 1'b0;
        accept     = 1'b0;
        St_Enable  = 1'b0;
        St_PushPop = 1'b0;
        St_I       = lat_q;
        St_Reset   = Reset;
        Res_Valid  = 1'b0;
        Error      = 1'b0;
        unique case (state)
            S_IDLE: begin
                tok_ready = 1'b1;
                if (tok.Tok_Valid) begin
                    accept = 1'b1;
                    unique case (kind_e'(tok.Tok_Kind))
                        K_OPND:
                            state_n = (depth == MAX_DEPTH) ? S_ERR : S_PUSH;
                        K_OPER:
                            state_n = (depth < TWO) ? S_ERR : S_POP_B;
                        K_END:
                            state_n = (depth != ONE) ? S_ERR : S_FIN;
                        default:
                            state_n = S_ERR;
                    endcase
                end
            end
            S_PUSH, S_PUSH_R: begin
                if (state == S_PUSH_R) St_I = r_q;
                if (St_Full) begin
                    state_n = S_ERR;
                end else begin
                    St_Enable = 1'b1;
                    depth_n   = depth + ONE;
                    state_n   = S_IDLE;
                end
            end
            S_POP_B, S_POP_A, S_FIN: begin
                if (St_Empty) begin
                    state_n = S_ERR;
                end else begin
                    St_Enable  = 1'b1;
                    St_PushPop = 1'b1;
                    depth_n    = depth - ONE;
                    unique case (state)
                        S_POP_B: state_n = S_POP_A;
                        S_POP_A: state_n = S_EXEC;
                        default: state_n = S_DONE;
                    endcase
                end
            end
            S_EXEC: state_n = S_PUSH_R;
            S_DONE: begin
                Res_Valid = 1'b1;
                St_Reset  = 1'b1;
                depth_n   = '0;
                state_n   = S_IDLE;
            end
            S_ERR: begin
                Error    = 1'b1;
                St_Reset = Reset | ~was_err;
            end
            default: state_n = S_ERR;
        endcase
        if (Clear) begin
            state_n   = S_IDLE;
            depth_n   = '0;
            tok_ready = 1'b0;
            accept    = 1'b0;
            St_Enable = 1'b0;
            St_Reset  = 1'b1;
        end
    end

    // Token latch, operand capture, ALU result and final result
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            lat_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            Result <= '0;
        end else begin
            if (accept) lat_q <= tok.Tok_Data;
            if (St_Enable && state == S_POP_B) b_q <= St_O;
            if (St_Enable && state == S_POP_A) a_q <= St_O;
            if (state == S_EXEC) r_q <= alu_r;
            if (St_Enable && state == S_FIN) Result <= St_O;
        end
    end

endmodule

// File: tb/tb_rpn_stack_engine.sv
// Bench for rpn_stack_engine paired with a pushdown stack
// model; vectors, corner sequences and random expressions.
module tb_rpn_stack_engine;

    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int MAXD = 7;

    logic CLK = 1'b0;
    logic Reset;
    logic Clear;
    logic [DW-1:0] Result, St_I, St_O;
    logic Res_Valid, Error, St_PushPop, St_Enable, St_Reset;
    logic St_Empty, St_Full;

    always #5 CLK = ~CLK;

    rpn_stack_engine_if #(.DATA_W(DW)) tok ();

    rpn_stack_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Clear      (Clear),
        .tok        (tok),
        .Result     (Result),
        .Res_Valid  (Res_Valid),
        .Error      (Error),
        .St_I       (St_I),
        .St_O       (St_O),
        .St_PushPop (St_PushPop),
        .St_Enable  (St_Enable),
        .St_Reset   (St_Reset),
        .St_Empty   (St_Empty),
        .St_Full    (St_Full)
    );

    // Pushdown stack model: O shows the top entry
    logic [DW-1:0] mem [0:7];
    int sp = 0;
    always @(posedge CLK) begin
        if (St_Reset === 1'b1) begin
            sp <= 0;
        end else if (St_Enable === 1'b1) begin
            if (St_PushPop) begin
                if (sp > 0) sp <= sp - 1;
            end else if (sp < 8) begin
                mem[3'(sp)] <= St_I;
                sp <= sp + 1;
            end
        end
    end
    assign St_O     = (sp > 0) ? mem[3'(sp - 1)] : '0;
    assign St_Empty = (sp == 0);
    assign St_Full  = (sp == MAXD);

    // Result pulse monitor
    int rv_cnt = 0;
    logic [DW-1:0] last_res = '0;
    always @(negedge CLK) begin
        if (Res_Valid === 1'b1) begin
            rv_cnt++;
            last_res = Result;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] k,
                        input logic [7:0] d,
                        output bit ok);
        int n = 0;
        @(negedge CLK);
        tok.Tok_Valid = 1'b1;
        tok.Tok_Kind  = k;
        tok.Tok_Data  = d;
        while (tok.Tok_Ready !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        ok = (tok.Tok_Ready === 1'b1);
        if (ok) begin
            @(posedge CLK);
            #1;
        end
        tok.Tok_Valid = 1'b0;
        if (!ok) chk("tok_timeout", 0, 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_clear();
        @(negedge CLK);
        Clear = 1'b1;
        @(negedge CLK);
        Clear = 1'b0;
        #1;
    endtask

    function automatic logic [9:0] o_(input logic [7:0] d);
        return {2'b00, d};
    endfunction
    function automatic logic [9:0] p_(input logic [1:0] op);
        return {2'b01, 6'd0, op};
    endfunction
    localparam logic [9:0] E_ = {2'b10, 8'd0};
    localparam logic [9:0] X_ = 10'd0;

    typedef struct packed {
        logic [3:0]       n;
        logic [7:0][9:0]  toks;
        logic             err;
        logic [7:0]       res;
    } vec_t;

    function automatic vec_t mk(input int n,
        input logic [9:0] t0, t1, t2, t3, t4, t5, t6, t7,
        input logic e, input logic [7:0] r);
        vec_t v;
        v.n = 4'(n);
        v.toks[0] = t0; v.toks[1] = t1;
        v.toks[2] = t2; v.toks[3] = t3;
        v.toks[4] = t4; v.toks[5] = t5;
        v.toks[6] = t6; v.toks[7] = t7;
        v.err = e;
        v.res = r;
        return v;
    endfunction

    function automatic int ref_op(input int a, b, op);
        int x;
        case (op)
            0: x = a + b;
            1: x = a - b;
            2: x = a & b;
            default: x = a ^ b;
        endcase
        return x & 255;
    endfunction

    task automatic finish_expr(input string tag, input int base,
                               input bit exp_err, input int exp_res);
        cycles(8);
        chk({tag, "_error"}, 32'(Error), 32'(exp_err));
        if (!exp_err) begin
            chk({tag, "_rvcount"}, rv_cnt - base, 1);
            chk({tag, "_result"}, 32'(last_res), exp_res);
            chk({tag, "_stack_empty"}, sp, 0);
        end else begin
            chk({tag, "_rvcount"}, rv_cnt - base, 0);
            chk({tag, "_ready_low"}, 32'(tok.Tok_Ready), 0);
        end
    endtask

    vec_t vecs [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int base;
        int q[$];
        int a, b, res, k;
        bit err, done;
        logic [7:0] d;

        vecs[0] = mk(4, o_(3), o_(4), p_(0), E_, X_, X_, X_, X_, 0, 7);
        vecs[1] = mk(4, o_(10), o_(3), p_(1), E_, X_, X_, X_, X_, 0, 7);
        vecs[2] = mk(4, o_(3), o_(10), p_(1), E_, X_, X_, X_, X_, 0, 249);
        vecs[3] = mk(4, o_(200), o_(100), p_(0), E_, X_, X_, X_, X_, 0, 44);
        vecs[4] = mk(4, o_(8'hF0), o_(8'h3C), p_(3), E_, X_, X_, X_, X_, 0, 8'hCC);
        vecs[5] = mk(4, o_(8'hF0), o_(8'h3C), p_(2), E_, X_, X_, X_, X_, 0, 8'h30);
        vecs[6] = mk(3, o_(5), o_(6), E_, X_, X_, X_, X_, X_, 1, 0);
        vecs[7] = mk(6, o_(1), o_(2), o_(3), p_(1), p_(0), E_, X_, X_, 0, 0);
        vecs[8] = mk(1, E_, X_, X_, X_, X_, X_, X_, X_, 1, 0);
        vecs[9] = mk(2, o_(1), {2'b11, 8'd0}, X_, X_, X_, X_, X_, X_, 1, 0);

        Reset = 1'b1;
        Clear = 1'b0;
        tok.Tok_Valid = 1'b0;
        tok.Tok_Kind  = 2'b00;
        tok.Tok_Data  = '0;
        cycles(3);
        chk("rst_st_reset", 32'(St_Reset), 1);
        chk("rst_error", 32'(Error), 0);
        chk("rst_res_valid", 32'(Res_Valid), 0);
        chk("rst_result", 32'(Result), 0);
        chk("rst_st_enable", 32'(St_Enable), 0);
        Reset = 1'b0;
        cycles(2);
        chk("idle_ready", 32'(tok.Tok_Ready), 1);
        chk("idle_st_reset", 32'(St_Reset), 0);

        // Push timing: one stack cycle, then back to IDLE
        send(2'b00, 8'h5A, ok);
        chk("push_enable", 32'(St_Enable), 1);
        chk("push_dir", 32'(St_PushPop), 0);
        chk("push_data", 32'(St_I), 32'h5A);
        chk("push_ready_low", 32'(tok.Tok_Ready), 0);
        @(posedge CLK);
        #1;
        chk("push_ready_back", 32'(tok.Tok_Ready), 1);
        chk("push_depth", sp, 1);
        do_clear();
        chk("clear_stack", sp, 0);

        for (int i = 0; i < 10; i++) begin
            do_clear();
            base = rv_cnt;
            for (int t = 0; t < int'(vecs[i].n); t++) begin
                send(vecs[i].toks[t][9:8], vecs[i].toks[t][7:0], ok);
                if (!ok) break;
            end
            finish_expr($sformatf("vec%0d", i), base,
                        vecs[i].err, int'(vecs[i].res));
        end

        // Underflow on operator: sticky error until Clear
        do_clear();
        send(2'b00, 8'd5, ok);
        send(2'b01, 8'd0, ok);
        chk("uf_error", 32'(Error), 1);
        chk("uf_ready", 32'(tok.Tok_Ready), 0);
        chk("uf_st_reset_entry", 32'(St_Reset), 1);
        cycles(3);
        chk("uf_sticky", 32'(Error), 1);
        chk("uf_ready_hold", 32'(tok.Tok_Ready), 0);
        chk("uf_no_stack_op", 32'(St_Enable), 0);
        chk("uf_st_reset_once", 32'(St_Reset), 0);
        chk("uf_stack_cleared", sp, 0);
        do_clear();
        chk("uf_clear_error", 32'(Error), 0);
        chk("uf_clear_ready", 32'(tok.Tok_Ready), 1);

        // Fill to MAX_DEPTH, then overflow
        for (int i = 0; i < MAXD; i++) send(2'b00, 8'(i + 1), ok);
        cycles(2);
        chk("full_no_error", 32'(Error), 0);
        chk("full_depth", sp, MAXD);
        send(2'b00, 8'd99, ok);
        chk("overflow_error", 32'(Error), 1);
        do_clear();

        // Clear wins over a concurrent token offer
        @(negedge CLK);
        Clear = 1'b1;
        tok.Tok_Valid = 1'b1;
        tok.Tok_Kind  = 2'b00;
        tok.Tok_Data  = 8'd9;
        #1;
        chk("clr_tok_ready", 32'(tok.Tok_Ready), 0);
        @(posedge CLK);
        #1;
        chk("clr_no_push", 32'(St_Enable), 0);
        @(negedge CLK);
        Clear = 1'b0;
        tok.Tok_Valid = 1'b0;
        cycles(2);
        chk("clr_no_accept", sp, 0);

        // Reset during POP_A
        base = rv_cnt;
        send(2'b00, 8'd3, ok);
        send(2'b00, 8'd4, ok);
        send(2'b01, 8'd0, ok);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        #1;
        chk("mid_st_reset", 32'(St_Reset), 1);
        chk("mid_error", 32'(Error), 0);
        chk("mid_res_valid", 32'(Res_Valid), 0);
        chk("mid_result", 32'(Result), 0);
        chk("mid_st_enable", 32'(St_Enable), 0);
        cycles(2);
        Reset = 1'b0;
        cycles(1);
        chk("mid_stack_cleared", sp, 0);
        chk("mid_no_result", rv_cnt - base, 0);
        send(2'b00, 8'd1, ok);
        send(2'b10, 8'd0, ok);
        finish_expr("after_reset", base, 0, 1);

        // Random expressions against an abstract evaluator
        for (int e = 0; e < 40; e++) begin
            do_clear();
            base = rv_cnt;
            q.delete();
            err = 0;
            done = 0;
            res = 0;
            for (int i = 0; i < 24 && !err && !done; i++) begin
                if ($urandom_range(0, 15) == 0)
                    k = $urandom_range(0, 3);
                else if (i >= 10)
                    k = (q.size() > 1) ? 1 : (q.size() == 1 ? 2 : 0);
                else if (q.size() < 2)
                    k = 0;
                else if (q.size() >= MAXD)
                    k = 1;
                else
                    k = $urandom_range(0, 1);
                d = 8'($urandom);
                case (k)
                    0: if (q.size() == MAXD) err = 1;
                       else q.push_back(int'(d));
                    1: if (q.size() < 2) err = 1;
                       else begin
                           b = q.pop_back();
                           a = q.pop_back();
                           q.push_back(ref_op(a, b, int'(d[1:0])));
                       end
                    2: if (q.size() != 1) err = 1;
                       else begin
                           res = q[0];
                           done = 1;
                       end
                    default: err = 1;
                endcase
                send(2'(k), d, ok);
                if (!ok) break;
            end
            if (err || done)
                finish_expr($sformatf("rnd%0d", e), base, err, res);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
